pipe_stage_hs: RTL and testbench
================================

Name: pipe_stage_hs

Overview:
- Generic handshaked pipeline register that replaces the fixed-enable inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) in the npc core.
- Adds a valid/ready handshake, back-pressure, an optional 2-entry skid buffer for full throughput with a registered ready, and flush for branch/exception redirect.
- Adds per-stage performance counters (transfers, stalls, bubbles) read by the simulation harness.
- One instance sits between each pair of stages; the payload is the stage's concatenated control/data bundle.

Parameters:
- DATA_W, 64, payload width in bits (must be ≥1).
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- CNT_W, 32, width of each performance counter (≥2).

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  payload held for downstream.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  payload to downstream.
- flush  in  1  discard all held entries.
- xfer_cnt  out  CNT_W  count of cycles with out_valid & out_ready.
- stall_cnt  out  CNT_W  count of cycles with out_valid & ~out_ready.
- bubble_cnt  out  CNT_W  count of cycles with ~out_valid & out_ready.

Behaviour:
- Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Reset (rst=1 at posedge): out_valid=0, out_data=0, skid data=0, all counters=0, state EMPTY. For SKID=1, in_ready=1 the cycle after reset.
- Reset overrides flush and all handshakes. Reset mid-transfer drops held data with no output.
- SKID=1 state machine:
  - Holds a main reg and a skid reg; out_data = main; out_valid = (state != EMPTY); in_ready is a registered flop = (next state != SKIDF).
  - EMPTY: in_fire → FULL, main <= in_data.
  - FULL, in_fire & out_fire → FULL, main <= in_data.
  - FULL, in_fire & ~out_fire → SKIDF, skid <= in_data.
  - FULL, ~in_fire & out_fire → EMPTY.
  - FULL, otherwise: hold.
  - SKIDF: in_ready=0, so in_fire is impossible. out_fire → FULL, main <= skid. Otherwise hold.
- SKID=0:
  - Single main reg; in_ready = ~out_valid | out_ready (combinational).
  - in_fire loads main and sets out_valid=1.
  - out_fire without in_fire clears out_valid.
- Latency and throughput: an accepted payload appears on out_data the cycle after in_fire (1-cycle latency). Sustained throughput is 1 per cycle in both modes when out_ready=1.
- Ordering is strictly FIFO. The skid entry is never overtaken.
- out_data and out_valid are stable while out_valid & ~out_ready (no change until out_fire or flush).
- Flush:
  - Next state EMPTY (out_valid=0, skid cleared); in_fire in the flush cycle is discarded. SKID=1: in_ready=1 next cycle.
  - An out_fire in the flush cycle still completes and counts in xfer_cnt.
  - Data regs are not cleared by flush; only valids are.
- Counters:
  - Each increments by 1 on its condition every non-reset cycle, including flush cycles.
  - Exactly one of xfer/stall/bubble increments when out_valid|out_ready, none when both are 0.
  - Wrap modulo 2^CNT_W with no saturation.
- in_valid is ignored while in_ready=0. Upstream must hold its payload, but the block does not check this.

Test Plan:
- Reset then stream, SKID=1, DATA_W=64, out_ready=1: in_data=0x10,0x20,0x30 on consecutive cycles → out_data 0x10,0x20,0x30 one cycle later each; in_ready stays 1; xfer_cnt=3, bubble_cnt=1 (first cycle).
- Back-pressure, SKID=1: send 0xA,0xB,0xC back-to-back with out_ready=0 → 0xA accepted, then 0xB into skid, then in_ready=0 and 0xC held upstream; stall_cnt counts each blocked cycle; release out_ready → outputs 0xA,0xB,0xC in order, no loss or duplication.
- Flush, SKID=1: with state SKIDF holding 0x1,0x2, assert flush plus in_valid=1 with 0x3 → next cycle out_valid=0 and in_ready=1; 0x3 never appears; counters unchanged except stall_cnt +1 for the flush cycle.
- SKID=0 comparison: same stimulus as the back-pressure case → in_ready drops combinationally when out_valid & ~out_ready; throughput 1/cycle with out_ready=1; ordering identical.
- Counter wrap, CNT_W=4: 17 transfers → xfer_cnt=1.
- Mid-operation reset: assert rst while out_valid=1 → next cycle out_valid=0, out_data=0, all counters=0, in_ready=1 (SKID=1).

Source files
------------

// File: rtl/pipe_stage_hs.sv
// Handshaked pipeline register between two core stages: valid/ready, optional
// 2-entry skid buffer (registered in_ready), flush, and per-stage perf counters.
module pipe_stage_hs #(
   parameter int DATA_W = 64,
   parameter int SKID   = 1,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   input  logic              flush,
   output logic [CNT_W-1:0]  xfer_cnt,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
);

   // Handshake: a beat moves when valid & ready are both high at posedge.
   // A producer holds valid and data stable until it sees ready.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKIDF = 2'd2
   } state_t;

   logic w_in_fire;
   logic w_out_fire;

   logic [CNT_W-1:0] r_xfer_cnt;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_bubble_cnt;

   assign w_in_fire  = in_valid & in_ready;
   assign w_out_fire = out_valid & out_ready;

   if (SKID != 0) begin : g_skid
      state_t            r_state;
      state_t            w_next_state;
      logic [DATA_W-1:0] r_main;
      logic [DATA_W-1:0] r_skid;
      logic              r_in_ready;
      logic              w_load_main;
      logic              w_main_from_skid;
      logic              w_load_skid;

      always_ff @(posedge clk) begin
         if (rst) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
         end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state != ST_SKIDF);
         end
      end

      // Flush empties the stage; any in_fire in that cycle is dropped.
      always_comb begin
         w_next_state     = r_state;
         w_load_main      = 1'b0;
         w_main_from_skid = 1'b0;
         w_load_skid      = 1'b0;
         if (flush) begin
            w_next_state = ST_EMPTY;
         end else begin
            case (r_state)
               ST_EMPTY: begin
                  if (w_in_fire) begin
                     w_next_state = ST_FULL;
                     w_load_main  = 1'b1;
                  end
               end
               ST_FULL: begin
                  if (w_in_fire && w_out_fire) begin
                     w_load_main = 1'b1;
                  end else if (w_in_fire) begin
                     w_next_state = ST_SKIDF;
                     w_load_skid  = 1'b1;
                  end else if (w_out_fire) begin
                     w_next_state = ST_EMPTY;
                  end
               end
               ST_SKIDF: begin
                  if (w_out_fire) begin
                     w_next_state     = ST_FULL;
                     w_main_from_skid = 1'b1;
                  end
               end
               default: w_next_state = ST_EMPTY;
            endcase
         end
      end

      always_comb begin
         out_valid = (r_state != ST_EMPTY);
         out_data  = r_main;
         in_ready  = r_in_ready;
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            r_main <= '0;
            r_skid <= '0;
         end else begin
            if (w_load_main) begin
               r_main <= in_data;
            end else if (w_main_from_skid) begin
               r_main <= r_skid;
            end
            if (w_load_skid) begin
               r_skid <= in_data;
            end
         end
      end
   end else begin : g_noskid
      logic              r_valid;
      logic [DATA_W-1:0] r_main;

      // Ready looks through to the downstream so a draining stage can refill.
      assign in_ready  = ~r_valid | out_ready;
      assign out_valid = r_valid;
      assign out_data  = r_main;

      always_ff @(posedge clk) begin
         if (rst) begin
            r_valid <= 1'b0;
            r_main  <= '0;
         end else if (flush) begin
            r_valid <= 1'b0;
         end else if (w_in_fire) begin
            r_valid <= 1'b1;
            r_main  <= in_data;
         end else if (w_out_fire) begin
            r_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_xfer_cnt   <= '0;
         r_stall_cnt  <= '0;
         r_bubble_cnt <= '0;
      end else begin
         if (out_valid && out_ready) begin
            r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
         end
         if (out_valid && !out_ready) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         end
         if (!out_valid && out_ready) begin
            r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
         end
      end
   end

   assign xfer_cnt   = r_xfer_cnt;
   assign stall_cnt  = r_stall_cnt;
   assign bubble_cnt = r_bubble_cnt;

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: three instances (skid, no-skid, skid with 4-bit counters)
// share one stimulus stream and are checked against an occupancy-based model.
module tb_pipe_stage_hs;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [63:0] in_data;
   logic        out_ready;
   logic        flush;

   logic        d_ir [3];
   logic        d_ov [3];
   logic [63:0] d_od [3];
   logic [31:0] d_x  [3];
   logic [31:0] d_s  [3];
   logic [31:0] d_b  [3];
   logic [3:0]  w_x4, w_s4, w_b4;

   int n_pass;
   int n_total;

   // Model: per instance an ordered list of held entries plus last shown head.
   logic [63:0] m_q [3][2];
   int          m_n [3];
   logic [63:0] m_held [3];
   int unsigned m_x [3];
   int unsigned m_s [3];
   int unsigned m_b [3];
   bit          m_init;

   typedef struct {
      logic        r;
      logic        iv;
      logic [63:0] d;
      logic        ordy;
      logic        fl;
      logic        e_ov;
      logic [63:0] e_od;
      logic        e_ir;
      logic [31:0] e_x;
      logic [31:0] e_s;
      logic [31:0] e_b;
   } vec_t;

   vec_t tbl [18];

   pipe_stage_hs #(.DATA_W(64), .SKID(1), .CNT_W(32)) u_skid (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d_ir[0]), .in_data(in_data),
      .out_valid(d_ov[0]), .out_ready(out_ready), .out_data(d_od[0]), .flush(flush),
      .xfer_cnt(d_x[0]), .stall_cnt(d_s[0]), .bubble_cnt(d_b[0])
   );

   pipe_stage_hs #(.DATA_W(64), .SKID(0), .CNT_W(32)) u_noskid (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d_ir[1]), .in_data(in_data),
      .out_valid(d_ov[1]), .out_ready(out_ready), .out_data(d_od[1]), .flush(flush),
      .xfer_cnt(d_x[1]), .stall_cnt(d_s[1]), .bubble_cnt(d_b[1])
   );

   pipe_stage_hs #(.DATA_W(64), .SKID(1), .CNT_W(4)) u_wrap (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d_ir[2]), .in_data(in_data),
      .out_valid(d_ov[2]), .out_ready(out_ready), .out_data(d_od[2]), .flush(flush),
      .xfer_cnt(w_x4), .stall_cnt(w_s4), .bubble_cnt(w_b4)
   );

   assign d_x[2] = {28'd0, w_x4};
   assign d_s[2] = {28'd0, w_s4};
   assign d_b[2] = {28'd0, w_b4};

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int cap(input int k);
      return (k == 1) ? 1 : 2;
   endfunction

   // Skid stage takes a beat whenever it has room; the single-register stage
   // also takes one when its only entry is leaving this cycle.
   function automatic logic m_rdy(input int k);
      return (m_n[k] < cap(k)) || ((k == 1) && out_ready);
   endfunction

   function automatic logic [31:0] cmask(input int k, input int unsigned v);
      return (k == 2) ? (v & 32'hF) : v;
   endfunction

   task automatic model_update();
      for (int k = 0; k < 3; k++) begin
         logic ov, inf, outf;
         ov   = (m_n[k] > 0);
         inf  = in_valid && m_rdy(k);
         outf = ov && out_ready;
         if (rst) begin
            m_n[k] = 0; m_held[k] = '0;
            m_x[k] = 0; m_s[k] = 0; m_b[k] = 0;
         end else begin
            if (ov && out_ready)  m_x[k]++;
            if (ov && !out_ready) m_s[k]++;
            if (!ov && out_ready) m_b[k]++;
            if (outf) begin
               m_q[k][0] = m_q[k][1];
               m_n[k]--;
            end
            if (flush) begin
               m_n[k] = 0;
            end else if (inf) begin
               m_q[k][m_n[k]] = in_data;
               m_n[k]++;
            end
            if (m_n[k] > 0) m_held[k] = m_q[k][0];
         end
      end
      if (rst) m_init = 1'b1;
   endtask

   task automatic check_all();
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("u%0d out_valid", k), d_ov[k], (m_n[k] > 0));
         chk($sformatf("u%0d out_data", k), d_od[k], m_held[k]);
         chk($sformatf("u%0d in_ready", k), d_ir[k], m_rdy(k));
         chk($sformatf("u%0d xfer_cnt", k), d_x[k], cmask(k, m_x[k]));
         chk($sformatf("u%0d stall_cnt", k), d_s[k], cmask(k, m_s[k]));
         chk($sformatf("u%0d bubble_cnt", k), d_b[k], cmask(k, m_b[k]));
      end
   endtask

   // driver: apply inputs, check pre-edge ready, clock, check post-edge state
   task automatic step(input logic r, input logic iv, input logic [63:0] d,
                       input logic ordy, input logic fl);
      rst = r; in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
      @(negedge clk);
      if (m_init) begin
         for (int k = 0; k < 3; k++) chk($sformatf("u%0d in_ready_pre", k), d_ir[k], m_rdy(k));
      end
      @(posedge clk);
      model_update();
      #1;
      if (m_init) check_all();
   endtask

   initial begin
      n_pass = 0; n_total = 0; m_init = 1'b0;
      for (int k = 0; k < 3; k++) begin
         m_n[k] = 0; m_held[k] = '0; m_x[k] = 0; m_s[k] = 0; m_b[k] = 0;
      end
      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;

      //            r  iv d      or fl  ov od     ir  x  s  b
      tbl[0]  = '{1, 0, 64'h0,  1, 0,  0, 64'h0,  1, 0, 0, 0};
      tbl[1]  = '{0, 1, 64'h10, 1, 0,  1, 64'h10, 1, 0, 0, 1};
      tbl[2]  = '{0, 1, 64'h20, 1, 0,  1, 64'h20, 1, 1, 0, 1};
      tbl[3]  = '{0, 1, 64'h30, 1, 0,  1, 64'h30, 1, 2, 0, 1};
      tbl[4]  = '{0, 0, 64'h0,  1, 0,  0, 64'h30, 1, 3, 0, 1};
      tbl[5]  = '{1, 0, 64'h0,  0, 0,  0, 64'h0,  1, 0, 0, 0};
      tbl[6]  = '{0, 1, 64'hA,  0, 0,  1, 64'hA,  1, 0, 0, 0};
      tbl[7]  = '{0, 1, 64'hB,  0, 0,  1, 64'hA,  0, 0, 1, 0};
      tbl[8]  = '{0, 1, 64'hC,  0, 0,  1, 64'hA,  0, 0, 2, 0};
      tbl[9]  = '{0, 1, 64'hC,  1, 0,  1, 64'hB,  1, 1, 2, 0};
      tbl[10] = '{0, 1, 64'hC,  1, 0,  1, 64'hC,  1, 2, 2, 0};
      tbl[11] = '{0, 0, 64'h0,  1, 0,  0, 64'hC,  1, 3, 2, 0};
      tbl[12] = '{0, 1, 64'h1,  0, 0,  1, 64'h1,  1, 3, 2, 0};
      tbl[13] = '{0, 1, 64'h2,  0, 0,  1, 64'h1,  0, 3, 3, 0};
      tbl[14] = '{0, 1, 64'h3,  0, 1,  0, 64'h1,  1, 3, 4, 0};
      tbl[15] = '{0, 0, 64'h0,  0, 0,  0, 64'h1,  1, 3, 4, 0};
      tbl[16] = '{0, 1, 64'h55, 0, 0,  1, 64'h55, 1, 3, 4, 0};
      tbl[17] = '{1, 1, 64'h66, 0, 0,  0, 64'h0,  1, 0, 0, 0};

      @(posedge clk);
      #1;

      // table: stream, back-pressure, flush in SKIDF, mid-operation reset
      for (int i = 0; i < 18; i++) begin
         step(tbl[i].r, tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl);
         chk($sformatf("tbl%0d out_valid", i), d_ov[0], tbl[i].e_ov);
         chk($sformatf("tbl%0d out_data", i), d_od[0], tbl[i].e_od);
         chk($sformatf("tbl%0d in_ready", i), d_ir[0], tbl[i].e_ir);
         chk($sformatf("tbl%0d xfer_cnt", i), d_x[0], tbl[i].e_x);
         chk($sformatf("tbl%0d stall_cnt", i), d_s[0], tbl[i].e_s);
         chk($sformatf("tbl%0d bubble_cnt", i), d_b[0], tbl[i].e_b);
      end

      // single-register stage: ready follows out_ready combinationally
      step(1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 64'hA, 1'b0, 1'b0);
      chk("ns holdA", d_od[1], 64'hA);
      in_valid = 1'b1; in_data = 64'hB; out_ready = 1'b0;
      #1;
      chk("ns ir stalled", d_ir[1], 1'b0);
      out_ready = 1'b1;
      #1;
      chk("ns ir draining", d_ir[1], 1'b1);
      step(1'b0, 1'b1, 64'hB, 1'b1, 1'b0);
      chk("ns outB", d_od[1], 64'hB);
      step(1'b0, 1'b1, 64'hC, 1'b1, 1'b0);
      chk("ns outC", d_od[1], 64'hC);
      chk("ns validC", d_ov[1], 1'b1);
      step(1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
      chk("ns drained", d_ov[1], 1'b0);

      // 17 transfers wrap a 4-bit counter to 1
      step(1'b1, 1'b0, 64'h0, 1'b1, 1'b0);
      for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 64'(i + 100), 1'b1, 1'b0);
      step(1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
      chk("wrap xfer4", d_x[2], 32'd1);
      chk("wide xfer32", d_x[0], 32'd17);
      chk("ns xfer32", d_x[1], 32'd17);

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 49) == 0), $urandom_range(0, 1),
              {$urandom, $urandom}, ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 19) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
